// File: rtl/fpu_dispatch_pkg.sv
// Shared definitions for the FPU dispatch slice.
//   - IEEE-754 single-precision field positions used by the classifier
//   - Conventional execution-unit indices for the attached FPU units
package fpu_dispatch_pkg;

   // Operand field layout (binary32)
   localparam int FP_SIGN     = 31;
   localparam int FP_EXP_MSB  = 30;
   localparam int FP_EXP_LSB  = 23;
   localparam int FP_FRCT_MSB = 22;
   localparam int FP_FRCT_LSB = 0;

   // Execution-unit indices on the unit select
   localparam int FPU_UNIT_CMP = 0;
   localparam int FPU_UNIT_ADD = 1;
   localparam int FPU_UNIT_MUL = 2;
   localparam int FPU_UNIT_DIV = 3;

endpackage

// File: rtl/fpu_classify.sv
// Combinational operand classifier.
// Ports:
//   value   - operand, BIT_WIDTH bits
//   is_inf  - exponent all ones, fraction zero
//   is_nan  - exponent all ones, fraction non-zero
//   is_zero - exponent and fraction zero (sign ignored)
// Denormals report all three flags low.
module fpu_classify
   import fpu_dispatch_pkg::*;
#(
   parameter int BIT_WIDTH = 32
) (
   input  logic [BIT_WIDTH-1:0] value,
   output logic                 is_inf,
   output logic                 is_nan,
   output logic                 is_zero
);

   logic [FP_EXP_MSB-FP_EXP_LSB:0]   exp_f;
   logic [FP_FRCT_MSB-FP_FRCT_LSB:0] frct_f;
   logic                             unused_sign;

   assign exp_f       = value[FP_EXP_MSB:FP_EXP_LSB];
   assign frct_f      = value[FP_FRCT_MSB:FP_FRCT_LSB];
   assign unused_sign = value[FP_SIGN];

   assign is_inf  = (&exp_f) & ~(|frct_f);
   assign is_nan  = (&exp_f) &  (|frct_f);
   assign is_zero = ~(|exp_f) & ~(|frct_f);

endmodule

// File: rtl/fpu_dispatch.sv
// Single-issue dispatcher between the core FPU request port and NUM_UNITS
// execution units.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   req_valid/req_ready            - request handshake; req_unit, req_a, req_b
//   rsp_valid/rsp_ready            - response handshake; rsp_lo, rsp_hi, rsp_err
//   unit_instr_received            - one-hot strobe, high for the whole operation
//   unit_params                    - {is_inf[1:0], is_nan[1:0], is_zero[1:0]}, [1]=reg1
//   unit_reg1/unit_reg2            - latched operands broadcast to all units
//   unit_instr_finished            - per-unit done
//   unit_lo/unit_hi                - flattened per-unit results
module fpu_dispatch
   import fpu_dispatch_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int NUM_UNITS = 4,
   parameter int UNIT_W    = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [UNIT_W-1:0]              req_unit,
   input  logic [BIT_WIDTH-1:0]           req_a,
   input  logic [BIT_WIDTH-1:0]           req_b,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [BIT_WIDTH-1:0]           rsp_lo,
   output logic [BIT_WIDTH-1:0]           rsp_hi,
   output logic                           rsp_err,
   output logic [NUM_UNITS-1:0]           unit_instr_received,
   output logic [5:0]                     unit_params,
   output logic [BIT_WIDTH-1:0]           unit_reg1,
   output logic [BIT_WIDTH-1:0]           unit_reg2,
   input  logic [NUM_UNITS-1:0]           unit_instr_finished,
   input  logic [NUM_UNITS*BIT_WIDTH-1:0] unit_lo,
   input  logic [NUM_UNITS*BIT_WIDTH-1:0] unit_hi
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t                 state;
   logic [UNIT_W-1:0]      sel;
   logic [CNT_W-1:0]       cnt;
   logic [NUM_UNITS-1:0]   req_onehot;
   logic                   unit_ok;
   logic                   fin_sel;
   logic [BIT_WIDTH-1:0]   lo_sel;
   logic [BIT_WIDTH-1:0]   hi_sel;
   logic                   a_inf, a_nan, a_zero;
   logic                   b_inf, b_nan, b_zero;

   fpu_classify #(.BIT_WIDTH(BIT_WIDTH)) u_cls_a (
      .value   (req_a),
      .is_inf  (a_inf),
      .is_nan  (a_nan),
      .is_zero (a_zero)
   );

   fpu_classify #(.BIT_WIDTH(BIT_WIDTH)) u_cls_b (
      .value   (req_b),
      .is_inf  (b_inf),
      .is_nan  (b_nan),
      .is_zero (b_zero)
   );

   // Decode of the requested unit; an out-of-range index decodes to all zeros,
   // which doubles as the invalid-unit indication.
   always_comb begin
      req_onehot = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (req_unit == UNIT_W'(k)) req_onehot[k] = 1'b1;
      end
   end
   assign unit_ok = |req_onehot;

   // Mux of the selected unit's completion and results
   always_comb begin
      fin_sel = 1'b0;
      lo_sel  = '0;
      hi_sel  = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (sel == UNIT_W'(k)) begin
            fin_sel = unit_instr_finished[k];
            lo_sel  = unit_lo[k*BIT_WIDTH +: BIT_WIDTH];
            hi_sel  = unit_hi[k*BIT_WIDTH +: BIT_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         sel                 <= '0;
         cnt                 <= '0;
         req_ready           <= 1'b1;
         rsp_valid           <= 1'b0;
         rsp_lo              <= '0;
         rsp_hi              <= '0;
         rsp_err             <= 1'b0;
         unit_instr_received <= '0;
         unit_params         <= '0;
         unit_reg1           <= '0;
         unit_reg2           <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready   <= 1'b0;
                  unit_reg1   <= req_a;
                  unit_reg2   <= req_b;
                  sel         <= req_unit;
                  unit_params <= {a_inf, b_inf, a_nan, b_nan, a_zero, b_zero};
                  cnt         <= '0;
                  if (unit_ok) begin
                     unit_instr_received <= req_onehot;
                     state               <= WAIT;
                  end else begin
                     rsp_err   <= 1'b1;
                     rsp_lo    <= '0;
                     rsp_hi    <= '0;
                     rsp_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt + 1'b1;
               // Completion takes priority over a coincident timeout
               if (fin_sel) begin
                  rsp_lo              <= lo_sel;
                  rsp_hi              <= hi_sel;
                  rsp_err             <= 1'b0;
                  rsp_valid           <= 1'b1;
                  unit_instr_received <= '0;
                  state               <= DONE;
               end else if (cnt == CNT_W'(TIMEOUT-1)) begin
                  rsp_lo              <= '0;
                  rsp_hi              <= '0;
                  rsp_err             <= 1'b1;
                  rsp_valid           <= 1'b1;
                  unit_instr_received <= '0;
                  state               <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
